ddr_frame_wr_packer: RTL and testbench

//  Upstream feeder of the DDR AXI write controller. Packs 16-bit camera pixels (RGB565)

---
 rtl/p_ddr.sv | 24 ++
 rtl/ddr_wr_fifo.sv | 58 +++++
 rtl/ddr_frame_wr_packer.sv | 199 +++++++++++++++++++
 tb/tb_ddr_frame_wr_packer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_ddr.sv
// Shared DDR write-path definitions: widths, queue entry layout, issue FSM states.
// Imported by the frame packer and its word FIFO.
package p_ddr;

    localparam int CTRL_ADDR_WIDTH = 28;
    localparam int MEM_DQ_WIDTH    = 32;
    localparam int WORD_WIDTH      = MEM_DQ_WIDTH * 8;
    localparam int PIX_WIDTH       = 16;
    localparam int PIX_PER_WORD    = WORD_WIDTH / PIX_WIDTH;
    localparam int ENTRY_WIDTH     = CTRL_ADDR_WIDTH + 1 + WORD_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_GAP  = 3'b100
    } wr_state_t;

    typedef struct packed {
        logic [CTRL_ADDR_WIDTH-1:0] addr;
        logic                       last;
        logic [WORD_WIDTH-1:0]      data;
    } wr_entry_t;

endpackage

// File: rtl/ddr_wr_fifo.sv
// Show-ahead synchronous FIFO for packed DDR words with their addresses.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module ddr_wr_fifo
    import p_ddr::*;
#(
    parameter int WIDTH = ENTRY_WIDTH,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/ddr_frame_wr_packer.sv
// Packs RGB565 pixels into 256-bit DDR words, queues them with frame addresses
// and hands them one at a time to the DDR write controller.
module ddr_frame_wr_packer
    import p_ddr::*;
#(
    parameter logic [CTRL_ADDR_WIDTH-1:0] BASE_ADDR = 28'h0000000,
    parameter int ADDR_STEP   = 8,
    parameter int FRAME_WORDS = 38400,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                       clk_100M,
    input  logic                       rst,
    input  logic                       init_done,
    input  logic                       frame_start,
    input  logic                       pix_valid,
    input  logic [PIX_WIDTH-1:0]       pix_data,
    output logic                       wr_req,
    output logic [CTRL_ADDR_WIDTH-1:0] wr_addr,
    output logic [3:0]                 wr_awlen,
    output logic [WORD_WIDTH-1:0]      wr_data,
    input  logic                       wr_done,
    output logic                       frame_done,
    output logic                       ovf_flag,
    output logic                       tmo_flag,
    output logic [2:0]                 fifo_level
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(FRAME_WORDS + 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(PIX_PER_WORD);

    logic [PW-1:0]              pix_cnt;
    logic [PW-1:0]              slot;
    logic [WORD_WIDTH-1:0]      pack_word;
    logic [WORD_WIDTH-1:0]      word_next;
    logic [CTRL_ADDR_WIDTH-1:0] pack_addr;
    logic [IW-1:0]              word_idx;
    logic                       word_full;
    logic                       word_last;
    wr_entry_t                  push_entry;

    logic [ENTRY_WIDTH-1:0]     head_bits;
    wr_entry_t                  head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [LW-1:0]              level;

    wr_state_t                  state;
    wr_state_t                  state_next;
    logic                       load;
    logic                       release_head;
    logic                       tmo_hit;
    logic [TW-1:0]              timer;

    assign wr_awlen = 4'd0;

    // A frame_start pixel lands in slot 0 of the fresh frame
    assign slot       = frame_start ? '0 : pix_cnt;
    assign word_full  = pix_valid && (slot == PW'(PIX_PER_WORD - 1));
    assign word_last  = (word_idx == IW'(FRAME_WORDS - 1));
    assign push_entry = '{addr: pack_addr, last: word_last, data: word_next};

    // Word image including the pixel arriving this cycle
    always_comb begin
        word_next = pack_word;
        word_next[slot*PIX_WIDTH +: PIX_WIDTH] = pix_data;
    end

    // Packer slot counter, word buffer and frame address walk
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            pix_cnt   <= '0;
            pack_word <= '0;
            pack_addr <= BASE_ADDR;
            word_idx  <= '0;
        end else begin
            if (frame_start) begin
                pix_cnt   <= '0;
                pack_addr <= BASE_ADDR;
                word_idx  <= '0;
            end
            if (pix_valid) begin
                pack_word <= word_next;
                pix_cnt   <= slot + PW'(1);
            end
            if (word_full) begin
                if (word_last) begin
                    pack_addr <= BASE_ADDR;
                    word_idx  <= '0;
                end else begin
                    pack_addr <= pack_addr + CTRL_ADDR_WIDTH'(ADDR_STEP);
                    word_idx  <= word_idx + IW'(1);
                end
            end
        end
    end

    ddr_wr_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_100M),
        .rst   (rst),
        .push  (word_full),
        .pop   (release_head),
        .din   (push_entry),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign head       = wr_entry_t'(head_bits);
    assign fifo_level = 3'(level);

    // Issue FSM state register
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && init_done) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wr_done || timer == TW'(TIMEOUT)) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Issue FSM decoded actions
    always_comb begin
        load         = 1'b0;
        release_head = 1'b0;
        tmo_hit      = 1'b0;
        case (state)
            ST_IDLE: load = !fifo_empty && init_done;
            ST_WAIT: begin
                release_head = wr_done;
                tmo_hit      = !wr_done && (timer == TW'(TIMEOUT));
            end
            default: ;
        endcase
    end

    // Completion timer, restarted on every request
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            timer <= '0;
        end else if (load) begin
            timer <= '0;
        end else if (state == ST_WAIT) begin
            timer <= timer + TW'(1);
        end
    end

    // Request registers, completion pulse and sticky error flags
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            ovf_flag   <= 1'b0;
            tmo_flag   <= 1'b0;
        end else begin
            frame_done <= release_head && head.last;
            if (load) begin
                wr_req  <= 1'b1;
                wr_addr <= head.addr;
                wr_data <= head.data;
            end else if (release_head || tmo_hit) begin
                wr_req <= 1'b0;
            end
            if (tmo_hit) begin
                tmo_flag <= 1'b1;
            end
            if (word_full && fifo_full && !release_head) begin
                ovf_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_frame_wr_packer.sv
// Randomized bench for ddr_frame_wr_packer against a queue-level reference model.
// Directed scenarios first, then a long random run with init_done toggling.
module tb_ddr_frame_wr_packer;

    localparam logic [27:0] BASE = 28'h0ABC000;
    localparam int STEP  = 8;
    localparam int FW    = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 31;

    typedef struct {
        logic [27:0]  addr;
        logic         last;
        logic [255:0] data;
    } ent_t;

    logic         clk_100M = 1'b0;
    logic         rst = 1'b1;
    logic         init_done = 1'b0;
    logic         frame_start = 1'b0;
    logic         pix_valid = 1'b0;
    logic [15:0]  pix_data = '0;
    logic         wr_req;
    logic [27:0]  wr_addr;
    logic [3:0]   wr_awlen;
    logic [255:0] wr_data;
    logic         wr_done = 1'b0;
    logic         frame_done;
    logic         ovf_flag;
    logic         tmo_flag;
    logic [2:0]   fifo_level;

    int compared = 0;
    int mismatched = 0;

    ent_t         q[$];
    logic [255:0] cur = '0;
    int           pc = 0;
    int           widx = 0;
    bit           m_ovf = 0;
    bit           m_tmo = 0;
    bit           m_fd = 0;
    bit           outstanding = 0;
    bit           just_end = 0;
    bit           init_s = 0;
    int           wait_cnt = 0;
    int           lat = 0;
    int           ack_cnt = 0;
    bit           withhold = 0;
    bit           prev_req = 0;
    int           n_issue = 0;
    int           fd_cnt = 0;
    logic [27:0]  iss_addr[$];
    logic [255:0] last_data = '0;

    ddr_frame_wr_packer #(
        .BASE_ADDR   (BASE),
        .ADDR_STEP   (STEP),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT     (TMO)
    ) dut (
        .clk_100M    (clk_100M),
        .rst         (rst),
        .init_done   (init_done),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_awlen    (wr_awlen),
        .wr_data     (wr_data),
        .wr_done     (wr_done),
        .frame_done  (frame_done),
        .ovf_flag    (ovf_flag),
        .tmo_flag    (tmo_flag),
        .fifo_level  (fifo_level)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: updated on each edge, compared half a cycle later
    initial begin
        forever begin
            @(posedge clk_100M);
            just_end = 0;
            init_s = init_done;
            if (rst) begin
                q.delete();
                pc = 0;
                widx = 0;
                m_ovf = 0;
                m_tmo = 0;
                m_fd = 0;
                outstanding = 0;
            end else begin
                m_fd = 0;
                if (outstanding && wr_done) begin
                    m_fd = q[0].last;
                    void'(q.pop_front());
                    outstanding = 0;
                    just_end = 1;
                end else if (outstanding) begin
                    wait_cnt++;
                    if (wait_cnt == TMO + 1) begin
                        m_tmo = 1;
                        outstanding = 0;
                        just_end = 1;
                    end
                end
                if (frame_start) begin
                    pc = 0;
                    widx = 0;
                end
                if (pix_valid) begin
                    cur[16*pc +: 16] = pix_data;
                    pc++;
                    if (pc == 16) begin
                        ent_t e;
                        e.addr = BASE + 28'(widx * STEP);
                        e.last = (widx == FW - 1);
                        e.data = cur;
                        if (q.size() < DEPTH) q.push_back(e);
                        else m_ovf = 1;
                        widx = (widx + 1) % FW;
                        pc = 0;
                    end
                end
            end

            @(negedge clk_100M);
            if (just_end) begin
                chk("req_drop", wr_req, 0);
            end else if (outstanding) begin
                chk("req_hold", wr_req, 1);
                chk("hold_addr", wr_addr, q[0].addr);
                chk("hold_data", wr_data, q[0].data);
            end else if (wr_req && !prev_req) begin
                chk("rise_init", init_s, 1);
                chk("rise_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("rise_addr", wr_addr, q[0].addr);
                    chk("rise_data", wr_data, q[0].data);
                end
                n_issue++;
                iss_addr.push_back(wr_addr);
                last_data = wr_data;
                outstanding = 1;
                wait_cnt = 0;
                ack_cnt = 0;
                lat = withhold ? 0 : $urandom_range(1, 20);
            end else begin
                chk("req_idle", wr_req, 0);
            end
            chk("fifo_level", fifo_level, q.size());
            chk("ovf_flag", ovf_flag, m_ovf);
            chk("tmo_flag", tmo_flag, m_tmo);
            chk("frame_done", frame_done, m_fd);
            chk("awlen", wr_awlen, 0);
            if (frame_done) fd_cnt++;
            if (outstanding && lat != 0) begin
                ack_cnt++;
                wr_done = (ack_cnt == lat);
            end else begin
                wr_done = 0;
            end
            prev_req = wr_req;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100M);
    endtask

    task automatic pix(input logic [15:0] d, input bit fs);
        @(negedge clk_100M);
        pix_valid = 1;
        pix_data = d;
        frame_start = fs;
        @(negedge clk_100M);
        pix_valid = 0;
        frame_start = 0;
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100M);
            pix_valid = 1;
            pix_data = 16'($urandom);
        end
        @(negedge clk_100M);
        pix_valid = 0;
    endtask

    task automatic fstart();
        @(negedge clk_100M);
        frame_start = 1;
        @(negedge clk_100M);
        frame_start = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || outstanding || wr_req) && n < 3000) begin
            @(negedge clk_100M);
            n++;
        end
        chk("drain_bound", n < 3000, 1);
        cyc(3);
    endtask

    initial begin
        int base_n;
        int base_fd;
        cyc(3);
        chk("rst_req", wr_req, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_flags", {ovf_flag, tmo_flag, frame_done}, 0);
        rst = 0;
        init_done = 1;
        cyc(2);

        // 1: one word of a ramp
        base_n = n_issue;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_100M);
            pix_valid = 1;
            pix_data = 16'(i);
        end
        @(negedge clk_100M);
        pix_valid = 0;
        drain();
        chk("t1_count", n_issue - base_n, 1);
        chk("t1_addr", iss_addr[base_n], BASE);
        chk("t1_lo", last_data[15:0], 16'h0000);
        chk("t1_hi", last_data[255:240], 16'h000F);
        chk("t1_level", fifo_level, 0);

        // 2: four back-to-back words
        fstart();
        base_n = n_issue;
        burst(64);
        drain();
        chk("t2_count", n_issue - base_n, 4);
        for (int i = 0; i < 4; i++)
            chk("t2_addr", iss_addr[base_n+i], BASE + 28'(8*i));
        chk("t2_ovf", ovf_flag, 0);

        // 3: frame wrap after FW words
        fstart();
        base_n = n_issue;
        base_fd = fd_cnt;
        burst(80);
        drain();
        chk("t3_count", n_issue - base_n, 5);
        chk("t3_wrap", iss_addr[base_n+4], BASE);
        chk("t3_fd", fd_cnt - base_fd, 1);

        // 4: partial word discarded by frame_start carrying a pixel
        fstart();
        base_n = n_issue;
        burst(7);
        pix(16'hAAAA, 1);
        burst(15);
        drain();
        chk("t4_count", n_issue - base_n, 1);
        chk("t4_addr", iss_addr[base_n], BASE);
        chk("t4_pix0", last_data[15:0], 16'hAAAA);

        // 5: held off by init_done, overflow
        fstart();
        init_done = 0;
        base_n = n_issue;
        burst(96);
        cyc(5);
        chk("t5_level", fifo_level, 4);
        chk("t5_ovf", ovf_flag, 1);
        chk("t5_noreq", n_issue - base_n, 0);
        init_done = 1;
        drain();
        chk("t5_count", n_issue - base_n, 4);
        for (int i = 0; i < 4; i++)
            chk("t5_addr", iss_addr[base_n+i], BASE + 28'(8*i));

        // 6: timeout then retry of the same entry
        fstart();
        withhold = 1;
        base_n = n_issue;
        burst(16);
        begin
            int n = 0;
            while (!tmo_flag && n < 200) begin
                @(negedge clk_100M);
                n++;
            end
            chk("t6_tmo_bound", n < 200, 1);
        end
        withhold = 0;
        drain();
        chk("t6_tmo", tmo_flag, 1);
        chk("t6_count", n_issue - base_n, 2);
        chk("t6_same", iss_addr[base_n+1], iss_addr[base_n]);
        @(negedge clk_100M);
        rst = 1;
        @(negedge clk_100M);
        rst = 0;
        chk("t6_clr", {tmo_flag, ovf_flag}, 0);

        // random run
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_100M);
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_data = 16'($urandom);
            frame_start = ($urandom_range(0, 299) == 0);
            if (c % 250 == 0) init_done = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk_100M);
        pix_valid = 0;
        frame_start = 0;
        init_done = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
